jcontrol: RTL

- Control section of the CPU, directly downstream of the clock generator and the six-step stepper.
- Consumes the one-hot step bus plus the enable and set clock phases. Produces gated register-enable and register-set strobes, the bus1 force and the ALU opcode.
- Owns the instruction register (IR) and the flags register (C, A, E, Z), so the CPU sequences fetch (steps 1-3) and execute (steps 4-6) with no extra glue.

---
 rtl/jcontrol_if.sv | 39 +++
 rtl/jcontrol.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/jcontrol_if.sv
// Signal bundle between the stepper/clock side and the jcontrol block.
// The master drives step, clock phases and data; the slave returns strobes and state.
interface jcontrol_if #(
  parameter int NREG = 4
);
  logic [0:5]      step;
  logic            clke;
  logic            clks;
  logic [7:0]      bus_in;
  logic [3:0]      flags_in;
  logic [0:NREG-1] r_e;
  logic [0:NREG-1] r_s;
  logic            ram_e;
  logic            ram_s;
  logic            acc_e;
  logic            acc_s;
  logic            iar_e;
  logic            iar_s;
  logic            mar_s;
  logic            tmp_s;
  logic            flags_s;
  logic            bus1;
  logic [2:0]      alu_op;
  logic [7:0]      ir;
  logic [3:0]      flags;
  logic            step_err;

  modport master (
    output step, clke, clks, bus_in, flags_in,
    input  r_e, r_s, ram_e, ram_s, acc_e, acc_s, iar_e, iar_s, mar_s, tmp_s,
           flags_s, bus1, alu_op, ir, flags, step_err
  );

  modport slave (
    input  step, clke, clks, bus_in, flags_in,
    output r_e, r_s, ram_e, ram_s, acc_e, acc_s, iar_e, iar_s, mar_s, tmp_s,
           flags_s, bus1, alu_op, ir, flags, step_err
  );
endinterface

// File: rtl/jcontrol.sv
// CPU control section: decodes step + IR into gated enable/set strobes,
// and holds the instruction register and the {C,A,E,Z} flags register.
module jcontrol #(
  parameter int NREG = 4
) (
  input  logic      clk,
  input  logic      reset,
  jcontrol_if.slave cb
);
  logic [7:0]      ir_q, ir_d;
  logic [3:0]      flags_q, flags_d;
  logic            clks_q, clks_d;
  logic            step_err_q, step_err_d;
  logic [2:0]      ones;
  logic            onehot, valid, gate_e, gate_s, load_ok;
  logic [1:0]      ra, rb;
  logic [0:NREG-1] r_e_dec, r_s_dec;
  logic            ram_e_dec, ram_s_dec, acc_e_dec, acc_s_dec;
  logic            iar_e_dec, iar_s_dec, mar_s_dec, tmp_s_dec;
  logic            flags_s_dec, ir_s_dec, bus1_dec, clf_dec;
  logic [2:0]      alu_op_dec;

  assign ra = ir_q[3:2];
  assign rb = ir_q[1:0];

  always_comb begin
    ones = '0;
    for (int i = 0; i < 6; i++) ones = ones + {2'b00, cb.step[i]};
  end

  assign onehot = (ones == 3'd1);
  assign valid  = onehot & ~reset;
  assign gate_e = cb.clke & valid;
  assign gate_s = cb.clks & valid;

  // Exact-match case: any non-one-hot step falls to default and decodes nothing.
  always_comb begin
    r_e_dec     = '0;
    r_s_dec     = '0;
    ram_e_dec   = 1'b0;
    ram_s_dec   = 1'b0;
    acc_e_dec   = 1'b0;
    acc_s_dec   = 1'b0;
    iar_e_dec   = 1'b0;
    iar_s_dec   = 1'b0;
    mar_s_dec   = 1'b0;
    tmp_s_dec   = 1'b0;
    flags_s_dec = 1'b0;
    ir_s_dec    = 1'b0;
    bus1_dec    = 1'b0;
    clf_dec     = 1'b0;
    alu_op_dec  = 3'b000;
    case (cb.step)
      6'b100000: begin
        bus1_dec = 1'b1; iar_e_dec = 1'b1; mar_s_dec = 1'b1; acc_s_dec = 1'b1;
      end
      6'b010000: begin
        ram_e_dec = 1'b1; ir_s_dec = 1'b1;
      end
      6'b001000: begin
        acc_e_dec = 1'b1; iar_s_dec = 1'b1;
      end
      6'b000100: begin
        if (ir_q[7]) begin
          r_e_dec[rb] = 1'b1; tmp_s_dec = 1'b1;
        end else begin
          case (ir_q[6:4])
            3'd0, 3'd1: begin r_e_dec[ra] = 1'b1; mar_s_dec = 1'b1; end
            3'd2, 3'd5: begin
              bus1_dec = 1'b1; iar_e_dec = 1'b1; mar_s_dec = 1'b1; acc_s_dec = 1'b1;
            end
            3'd3:    begin r_e_dec[rb] = 1'b1; iar_s_dec = 1'b1; end
            3'd4:    begin iar_e_dec = 1'b1; mar_s_dec = 1'b1; end
            3'd6:    begin bus1_dec = 1'b1; flags_s_dec = 1'b1; clf_dec = 1'b1; end
            default: ;
          endcase
        end
      end
      6'b000010: begin
        if (ir_q[7]) begin
          r_e_dec[ra] = 1'b1; alu_op_dec = ir_q[6:4];
          acc_s_dec = 1'b1; flags_s_dec = 1'b1;
        end else begin
          case (ir_q[6:4])
            3'd0, 3'd2: begin ram_e_dec = 1'b1; r_s_dec[rb] = 1'b1; end
            3'd1:       begin r_e_dec[rb] = 1'b1; ram_s_dec = 1'b1; end
            3'd4:       begin ram_e_dec = 1'b1; iar_s_dec = 1'b1; end
            3'd5:       begin acc_e_dec = 1'b1; iar_s_dec = 1'b1; end
            default: ;
          endcase
        end
      end
      6'b000001: begin
        // CMP (ALU op 111) only updates flags; its write-back step is silent.
        if (ir_q[7]) begin
          if (ir_q[6:4] != 3'b111) begin
            acc_e_dec = 1'b1; r_s_dec[rb] = 1'b1;
          end
        end else if (ir_q[6:4] == 3'd2) begin
          acc_e_dec = 1'b1; iar_s_dec = 1'b1;
        end else if (ir_q[6:4] == 3'd5 && (ir_q[3:0] & flags_q) != 4'b0000) begin
          ram_e_dec = 1'b1; iar_s_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cb.r_e     = r_e_dec & {NREG{gate_e}};
  assign cb.r_s     = r_s_dec & {NREG{gate_s}};
  assign cb.ram_e   = ram_e_dec & gate_e;
  assign cb.ram_s   = ram_s_dec & gate_s;
  assign cb.acc_e   = acc_e_dec & gate_e;
  assign cb.acc_s   = acc_s_dec & gate_s;
  assign cb.iar_e   = iar_e_dec & gate_e;
  assign cb.iar_s   = iar_s_dec & gate_s;
  assign cb.mar_s   = mar_s_dec & gate_s;
  assign cb.tmp_s   = tmp_s_dec & gate_s;
  assign cb.flags_s = flags_s_dec & gate_s;
  assign cb.bus1    = bus1_dec & valid;
  assign cb.alu_op  = valid ? alu_op_dec : 3'b000;

  // Internal loads fire once per set pulse, on the edge that first sees clks high.
  assign load_ok = cb.clks & ~clks_q & onehot;

  always_comb begin
    ir_d       = ir_q;
    flags_d    = flags_q;
    clks_d     = cb.clks;
    step_err_d = step_err_q | ~onehot;
    if (load_ok && ir_s_dec) ir_d = cb.bus_in;
    if (load_ok && flags_s_dec) flags_d = clf_dec ? 4'b0000 : cb.flags_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q       <= 8'h00;
      flags_q    <= 4'b0000;
      clks_q     <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      flags_q    <= flags_d;
      clks_q     <= clks_d;
      step_err_q <= step_err_d;
    end
  end

  assign cb.ir       = ir_q;
  assign cb.flags    = flags_q;
  assign cb.step_err = step_err_q;
endmodule
